// File: rtl/ui_pkg.sv
// Shared definitions for the front-panel button logic.
//   BTN_W                number of front-panel push buttons
//   SYNC_STAGES_DEF      default synchroniser depth per button
//   DEBOUNCE_CYCLES_DEF  default debounce length (0 = debounce bypassed)
//   btn_vec_t            one bit per button, bit i = button i
//   cnt_width()          debounce counter width, never narrower than 1 bit
package ui_pkg;

    localparam int BTN_W               = 4;
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 0;

    typedef logic [BTN_W-1:0] btn_vec_t;

    function automatic int cnt_width(input int cycles);
        return (cycles > 0) ? $clog2(cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/btn_sync_debounce.sv
// Single-button front end: synchroniser chain followed by an optional debounce
// filter. The output is the accepted (filtered) button level.
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   btn_raw   in   raw button level, asynchronous to clk
//   accepted  out  filtered level; combinational from the sync chain when
//                  debounce is bypassed, otherwise a flop
module btn_sync_debounce
    import ui_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic accepted
);

    logic s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = btn_raw;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            logic [SYNC_STAGES-1:0] sync_d;

            // Bit 0 takes the raw input; the MSB is the synchronised level.
            always_comb begin
                sync_d = (sync_q << 1) | SYNC_STAGES'(btn_raw);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
            assign accepted = s;
        end else begin : g_deb
            localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             acc_q;
            logic             acc_d;

            // The new level is taken on the edge that would make the counter
            // reach DEBOUNCE_CYCLES, so the filter adds exactly DEBOUNCE_CYCLES
            // of latency. Any cycle where s agrees with acc_q restarts the count.
            always_comb begin
                cnt_d = '0;
                acc_d = acc_q;
                if (s != acc_q) begin
                    if (cnt_q == CNT_LAST) begin
                        acc_d = s;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                    acc_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    acc_q <= acc_d;
                end
            end

            assign accepted = acc_q;
        end
    endgenerate

endmodule

// File: rtl/button_release_detector.sv
// Per-button release detector for the front-panel push buttons. Each button is
// synchronised (and optionally debounced), and a one-cycle RELEASE pulse is
// produced when its accepted level falls 1->0. Presses never pulse.
// Ports:
//   CLOCK    in   system clock, rising edge
//   RESET    in   asynchronous active-low reset
//   BUTTONS  in   raw button levels, 1 = pressed
//   RELEASE  out  registered one-cycle pulse per release, bit i = button i
module button_release_detector
    import ui_pkg::*;
#(
    parameter int WIDTH           = BTN_W,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] BUTTONS,
    output logic [WIDTH-1:0] RELEASE
);

    logic [WIDTH-1:0] accepted;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;
    logic [WIDTH-1:0] release_q;
    logic [WIDTH-1:0] release_d;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_btn
            btn_sync_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_sync_debounce (
                .clk      (CLOCK),
                .rst_n    (RESET),
                .btn_raw  (BUTTONS[i]),
                .accepted (accepted[i])
            );
        end
    endgenerate

    // prev clears in reset, so a button held through reset release cannot
    // look like a falling edge.
    always_comb begin
        prev_d    = accepted;
        release_d = prev_q & ~accepted;
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            prev_q    <= '0;
            release_q <= '0;
        end else begin
            prev_q    <= prev_d;
            release_q <= release_d;
        end
    end

    assign RELEASE = release_q;

endmodule

// File: tb/tb_button_release_detector.sv
module tb_button_release_detector;
    import ui_pkg::*;

    logic     clock;
    logic     reset;
    btn_vec_t buttons;
    btn_vec_t release_o;
    btn_vec_t buttons_db;
    btn_vec_t release_db;

    int errors = 0;
    int checks = 0;

    btn_vec_t hist[$];
    btn_vec_t exp_rel;
    btn_vec_t exp_db;

    button_release_detector u_dut (
        .CLOCK   (clock),
        .RESET   (reset),
        .BUTTONS (buttons),
        .RELEASE (release_o)
    );

    button_release_detector #(
        .WIDTH           (BTN_W),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) u_dut_db (
        .CLOCK   (clock),
        .RESET   (reset),
        .BUTTONS (buttons_db),
        .RELEASE (release_db)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input btn_vec_t obs, input btn_vec_t expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        hist = {};
        repeat (4) hist.push_back('0);
    endtask

    // Reference: with debounce bypassed and 2 sync stages, RELEASE after edge n
    // is high for a bit that was sampled 1 at edge n-3 and 0 at edge n-2.
    task automatic tick(input string tag);
        @(posedge clock);
        #1;
        if (!reset) begin
            model_clear();
            exp_rel = '0;
        end else begin
            hist.push_back(buttons);
            if (hist.size() > 8) void'(hist.pop_front());
            exp_rel = hist[hist.size()-4] & ~hist[hist.size()-3];
        end
        check(tag, release_o, exp_rel);
        check({tag, "_db"}, release_db, exp_db);
    endtask

    int pulses;

    initial begin
        reset      = 1'b1;
        buttons    = 4'b1111;
        buttons_db = '0;
        exp_db     = '0;
        model_clear();

        // Reset with all buttons held, then release reset with them still held.
        #1 reset = 1'b0;
        #1;
        check("reset_state", release_o, 4'b0000);
        check("reset_state_db", release_db, 4'b0000);
        repeat (2) tick("in_reset");
        reset = 1'b1;
        repeat (6) tick("held_at_startup");

        // Directed release pattern, one cycle per vector.
        buttons = 4'b0000; tick("seq");
        buttons = 4'b1010; tick("seq");
        buttons = 4'b0101; tick("seq");
        buttons = 4'b0000; tick("seq");
        buttons = 4'b0110; tick("seq");
        buttons = 4'b0001; tick("seq");
        buttons = 4'b0100; tick("seq");
        buttons = 4'b0000;
        repeat (6) tick("seq_tail");

        // Press held: never a pulse.
        buttons = 4'b1111;
        repeat (10) tick("press_only");

        // Release held: exactly one all-ones pulse.
        buttons = 4'b0000;
        pulses  = 0;
        for (int k = 1; k <= 20; k++) begin
            tick("release_held");
            if (release_o == 4'b1111) pulses++;
            if (k == 3) check("release_latency", release_o, 4'b1111);
        end
        check_int("release_pulse_count", pulses, 1);

        // Back-to-back toggles on bit 1: one pulse per falling edge.
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            buttons = (k % 2 == 0) ? 4'b0010 : 4'b0000;
            tick("toggle");
            if (release_o[1]) pulses++;
        end
        buttons = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            tick("toggle_tail");
            if (release_o[1]) pulses++;
        end
        check_int("toggle_pulse_count", pulses, 8);

        // Press on one bit, release on another in the same cycle.
        buttons = 4'b1001; repeat (4) tick("mixed");
        buttons = 4'b0110; repeat (5) tick("mixed");
        buttons = 4'b0000; repeat (5) tick("mixed");

        // Randomised levels against the delay-line model.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(1, 0) == 1) buttons = btn_vec_t'($urandom);
            tick("random");
        end
        buttons = 4'b0000;
        repeat (5) tick("random_tail");

        // Debounced instance: short glitch is filtered, held release pulses once.
        buttons_db = 4'b0001;
        repeat (10) tick("db_high");
        buttons_db = 4'b0000;
        repeat (2) tick("db_glitch");
        buttons_db = 4'b0001;
        repeat (10) tick("db_high_again");
        buttons_db = 4'b0000;
        for (int k = 1; k <= 12; k++) begin
            exp_db = (k == 7) ? 4'b0001 : 4'b0000;
            tick("db_release");
        end
        exp_db = '0;

        // Asynchronous clear while a pulse is on the output.
        buttons = 4'b0100; tick("pre_reset");
        buttons = 4'b0000;
        repeat (3) tick("pre_reset");
        check("pulse_before_reset", release_o, 4'b0100);
        reset = 1'b0;
        #1;
        check("async_clear", release_o, 4'b0000);
        tick("mid_reset");
        reset = 1'b1;
        repeat (5) tick("after_reset");

        // Release in flight at reset is lost.
        buttons = 4'b1000; repeat (4) tick("inflight");
        buttons = 4'b0000; tick("inflight");
        reset = 1'b0;
        tick("inflight_reset");
        reset = 1'b1;
        repeat (5) tick("inflight_lost");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
